// File: rtl/uart_note_rx.sv
// ---------------------------------------------------------------------------
// uart_note_rx
// 8N1 serial receiver for remote note commands. Each received byte updates a
// held-note bitmap and the scale select, in the same format as the physical
// keyboard, so a host can play the instrument over a serial link.
//
// Byte format: [7] on(1)/off(0), [6:4] scale field, [3:0] key index.
//   key 0..NUM_KEYS-1 : set/clear that key, other keys untouched
//   key 13,14         : key field ignored, scale still applied
//   key 15            : all keys released
//   scale 0 keeps, 1..5 loads, 6/7 saturate to 5
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset_n    in   asynchronous reset, ACTIVE-HIGH despite the name
//   rx         in   serial line, idle high, asynchronous to clk
//   keys       out  held-note bitmap, bit k = key k on
//   scale      out  scale select 1..5
//   rx_byte    out  last correctly framed byte
//   byte_valid out  one-cycle pulse when rx_byte/keys/scale update
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//
// Optional feature macro: NOTE_TIMEOUT_EN
//   When defined, keys are released after TIMEOUT_MS of no received byte.
// ---------------------------------------------------------------------------
module uart_note_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 9600,
  parameter int NUM_KEYS   = 13,
  parameter int TIMEOUT_MS = 500
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx,
  output logic [NUM_KEYS-1:0] keys,
  output logic [2:0]          scale,
  output logic [7:0]          rx_byte,
  output logic                byte_valid,
  output logic                frame_err
);

  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV + 1);

  localparam logic [CW-1:0]       CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]       CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0]       DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]       HALF_LAST = CW'(HALF - 1);
  localparam logic [NUM_KEYS-1:0] KEY_ONE   = NUM_KEYS'(1'b1);
  localparam logic [NUM_KEYS-1:0] KEY_NONE  = {NUM_KEYS{1'b0}};

  generate
    if (DIV < 2) begin : g_div_check
      $error("uart_note_rx: CLK_HZ/BAUD must be at least 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK,
    S_DECODE
  } state_t;

  // Apply one command byte to the held-note bitmap.
  function automatic logic [NUM_KEYS-1:0] apply_keys(input logic [NUM_KEYS-1:0] cur,
                                                     input logic [7:0]          cmd);
    logic [NUM_KEYS-1:0] mask;
    logic [NUM_KEYS-1:0] res;
    mask = KEY_ONE << cmd[3:0];
    res  = cur;
    if (cmd[3:0] == 4'hF) begin
      res = KEY_NONE;
    end else if (int'(cmd[3:0]) < NUM_KEYS) begin
      if (cmd[7]) begin
        res = cur | mask;
      end else begin
        res = cur & ~mask;
      end
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Apply the scale field: 0 keeps, 1..5 load, 6/7 saturate at 5.
  function automatic logic [2:0] apply_scale(input logic [2:0] cur,
                                             input logic [2:0] field);
    logic [2:0] res;
    case (field)
      3'd0:                         res = cur;
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: res = field;
      3'd6, 3'd7:                   res = 3'd5;
      default:                      res = cur;
    endcase
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                rx_meta_q, rx_sync_q;
  logic [NUM_KEYS-1:0] keys_q, keys_d;
  logic [2:0]          scale_q, scale_d;
  logic [7:0]          rx_byte_q, rx_byte_d;
  logic                byte_valid_q, byte_valid_d;
  logic                frame_err_q, frame_err_d;

`ifdef NOTE_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_MS * (CLK_HZ / 1000);
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] IDLE_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] IDLE_ONE  = TW'(1'b1);
  localparam logic [TW-1:0] IDLE_MAX  = TW'(TO_CYC);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TO_CYC - 1);
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;
`endif

  // Next-state, datapath and output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    keys_d       = keys_q;
    scale_d      = scale_q;
    rx_byte_d    = rx_byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_ZERO;
        if (!rx_sync_q) begin
          state_d   = S_START;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end

      // Recheck at mid start bit so a short low glitch is dropped silently.
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = CNT_ZERO;
          if (!rx_sync_q) begin
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // LSB arrives first, so shift in from the top.
      S_DATA: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = CNT_ZERO;
          shift_d = {rx_sync_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = CNT_ZERO;
          if (rx_sync_q) begin
            state_d = S_DECODE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      // A line held low after a bad frame must go high before a new start.
      S_BREAK: begin
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end

      S_DECODE: begin
        rx_byte_d    = shift_q;
        byte_valid_d = 1'b1;
        keys_d       = apply_keys(keys_q, shift_q);
        scale_d      = apply_scale(scale_q, shift_q[6:4]);
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef NOTE_TIMEOUT_EN
    // Release all notes once the host has been silent for the timeout.
    idle_cnt_d = idle_cnt_q;
    if (state_q == S_DECODE) begin
      idle_cnt_d = IDLE_ZERO;
    end else if (idle_cnt_q == IDLE_MAX) begin
      idle_cnt_d = IDLE_MAX;
    end else if (idle_cnt_q == IDLE_LAST) begin
      idle_cnt_d = IDLE_MAX;
      keys_d     = KEY_NONE;
    end else begin
      idle_cnt_d = idle_cnt_q + IDLE_ONE;
    end
`endif
  end

  // State, synchronizer and registered outputs.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      keys_q       <= KEY_NONE;
      scale_q      <= 3'd1;
      rx_byte_q    <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef NOTE_TIMEOUT_EN
      idle_cnt_q   <= IDLE_ZERO;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_meta_q    <= rx;
      rx_sync_q    <= rx_meta_q;
      keys_q       <= keys_d;
      scale_q      <= scale_d;
      rx_byte_q    <= rx_byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef NOTE_TIMEOUT_EN
      idle_cnt_q   <= idle_cnt_d;
`endif
    end
  end

  assign keys       = keys_q;
  assign scale      = scale_q;
  assign rx_byte    = rx_byte_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_note_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_note_rx
// Directed and randomized serial frames into uart_note_rx, with a command
// model kept in the bench. A fast bit rate (DIV = 16) keeps runs short.
// ---------------------------------------------------------------------------
module tb_uart_note_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 62_500;
  localparam int DIV    = CLK_HZ / BAUD;

  logic        clk;
  logic        reset_n;
  logic        rx;
  logic [12:0] keys;
  logic [2:0]  scale;
  logic [7:0]  rx_byte;
  logic        byte_valid;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  int bv_hi  = 0;
  int fe_hi  = 0;
  int exp_bv = 0;
  int exp_fe = 0;

  // Reference state
  logic [12:0] ref_keys;
  int          ref_scale;
  logic [7:0]  ref_byte;

  uart_note_rx #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .NUM_KEYS  (13),
    .TIMEOUT_MS(1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .keys      (keys),
    .scale     (scale),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high cycles of each pulse; they must never overlap.
  always @(negedge clk) begin
    if (byte_valid === 1'b1) bv_hi++;
    if (frame_err === 1'b1) fe_hi++;
    assert (!(byte_valid === 1'b1 && frame_err === 1'b1)) else begin
      errors++;
      $error("FAIL pulse_overlap observed=both_high expected=exclusive");
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ref_keys  = 13'h0000;
    ref_scale = 1;
    ref_byte  = 8'h00;
  endtask

  // Command semantics from the byte-format rules.
  task automatic model_apply(input logic [7:0] b);
    int k;
    int f;
    k = int'(b[3:0]);
    f = int'(b[6:4]);
    ref_byte = b;
    if (k == 15) ref_keys = 13'h0000;
    else if (k < 13) ref_keys[k] = b[7];
    if (f != 0) ref_scale = (f > 5) ? 5 : f;
    exp_bv++;
  endtask

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_bit);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_keys"},  16'(keys),       16'(ref_keys));
    check({tag, "_scale"}, 16'(scale),      16'(ref_scale));
    check({tag, "_byte"},  16'(rx_byte),    16'(ref_byte));
    check({tag, "_bv"},    16'(bv_hi),      16'(exp_bv));
    check({tag, "_fe"},    16'(fe_hi),      16'(exp_fe));
  endtask

  task automatic do_byte(input logic [7:0] b, input string tag);
    send_frame(b, 1'b1);
    repeat (DIV) @(negedge clk);
    model_apply(b);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rb;
    rx      = 1'b1;
    reset_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);
    check("rst_keys",  16'(keys),       16'h0000);
    check("rst_scale", 16'(scale),      16'h0001);
    check("rst_byte",  16'(rx_byte),    16'h0000);
    check("rst_bv",    16'(byte_valid), 16'h0000);
    check("rst_fe",    16'(frame_err),  16'h0000);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    // Directed decode sequence with literal expectations
    do_byte(8'h93, "b93");
    check("b93_lit", 16'(keys), 16'h0008);
    do_byte(8'hDC, "bDC");
    check("bDC_lit", 16'({scale, keys}), 16'hB008);
    do_byte(8'h0F, "b0F");
    check("b0F_lit", 16'({scale, keys}), 16'hA000);

    // Short low glitch, shorter than half a bit: dropped silently
    rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    check_all("glitch");

    // Bad stop bit, then the line stays low
    send_frame(8'h85, 1'b0);
    repeat (DIV) @(negedge clk);
    exp_fe++;
    check_all("ferr");
    repeat (400) @(negedge clk);
    check_all("break_hold");
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check_all("break_rel");

    // Scale saturation and key-13 ignore, then scale-0 keep
    do_byte(8'hA5, "bA5");
    do_byte(8'hED, "bED");
    check("bED_lit", 16'({scale, keys}), 16'hA020);
    do_byte(8'h80, "b80");
    check("b80_lit", 16'({scale, keys}), 16'hA021);

    // Reset in the middle of the data bits
    hold_bit(1'b0);
    hold_bit(1'b1);
    hold_bit(1'b1);
    do_reset();
    repeat (12 * DIV) @(negedge clk);
    check_all("mid_rst");
    do_byte(8'h91, "b91");
    check("b91_lit", 16'({scale, keys}), 16'h2002);

    // Random commands
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom_range(0, 255));
      do_byte(rb, "rnd");
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

`ifdef NOTE_TIMEOUT_EN
    // Silence after a byte releases the keys but keeps the scale
    do_reset();
    do_byte(8'h93, "to_b93");
    repeat (1500) @(negedge clk);
    ref_keys = 13'h0000;
    check_all("timeout");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
